fabric_config_loader: RTL and testbench

Sequences configuration of the tile array. It accepts a framed stream of 32-bit words (record count, address/data pairs, checksum) and replays each record onto the shared `config_addr`/`config_data` bus as a single-cycle write, separated by idle cycles. It validates section codes and a running XOR checksum, and reports done or error. It sits between the bitstream source (SPI/UART front end or ROM reader) and the top-level fabric config bus that feeds every tile's `config_en` decode.

---
 rtl/fabric_config_pkg.sv | 30 +++
 rtl/fabric_config_loader.sv | 157 +++++++++++++++
 tb/tb_fabric_config_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fabric_config_pkg.sv
// Shared definitions for the fabric config loader and the tile decoders.
package fabric_config_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HEADER,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_GAP,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [15:0] CONFIG_SB  = 16'd7;
    localparam logic [15:0] CONFIG_CB0 = 16'd6;
    localparam logic [15:0] CONFIG_CB1 = 16'd5;
    localparam logic [15:0] CONFIG_CLB = 16'd4;

    // Section 16'hFFFF matches no sub-block, so the bus is harmless when parked here.
    localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'hFFFF_0000;

    // True when the section field addresses one of the configurable sub-blocks.
    function automatic logic section_ok(input logic [15:0] sec);
        return (sec == CONFIG_SB) || (sec == CONFIG_CB0) ||
               (sec == CONFIG_CB1) || (sec == CONFIG_CLB);
    endfunction

endpackage

// File: rtl/fabric_config_loader.sv
// Parses a framed config stream (count, addr/data pairs, XOR checksum) and
// replays each record onto the fabric config bus as a one-cycle write.
module fabric_config_loader
    import fabric_config_pkg::*;
#(
    parameter int          GAP_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR  = IDLE_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] records_written
);

    localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e         state_q, state_d;
    logic [15:0]    n_q, n_d;
    logic [31:0]    acc_q, acc_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    data_q, data_d;
    logic [15:0]    rec_q, rec_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [31:0]    cfg_addr_q, cfg_addr_d;
    logic [31:0]    cfg_data_q, cfg_data_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           xfer;
    logic [15:0]    rec_inc;

    // in_ready_q always reflects the current state, so it is a valid handshake term.
    assign xfer    = in_valid & in_ready_q;
    assign rec_inc = rec_q + 16'd1;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rec_d   = rec_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    rec_d   = '0;
                    acc_d   = '0;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (xfer) begin
                    n_d   = in_data[15:0];
                    acc_d = in_data;
                    if (in_data[31:16] != 16'd0)      state_d = S_ERR;
                    else if (in_data[15:0] == 16'd0)  state_d = S_CHECK;
                    else                              state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (xfer) begin
                    acc_d = acc_q ^ in_data;
                    if (!section_ok(in_data[31:16])) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d  = in_data;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    acc_d   = acc_q ^ in_data;
                    data_d  = in_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                rec_d = rec_inc;
                gap_d = '0;
                if (GAP_CYCLES == 0) state_d = (rec_inc < n_q) ? S_ADDR : S_CHECK;
                else                 state_d = S_GAP;
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = (rec_q < n_q) ? S_ADDR : S_CHECK;
                else                   gap_d   = gap_q + GW'(1);
            end
            S_CHECK: begin
                if (xfer) state_d = (in_data == acc_q) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so nothing on in_* reaches the bus combinationally.
        in_ready_d = (state_d == S_HEADER) || (state_d == S_ADDR) ||
                     (state_d == S_DATA)   || (state_d == S_CHECK);
        busy_d     = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
        cfg_addr_d = (state_d == S_WRITE) ? addr_d : IDLE_ADDR;
        cfg_data_d = (state_d == S_WRITE) ? data_d : 32'd0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rec_q      <= '0;
            gap_q      <= '0;
            cfg_addr_q <= IDLE_ADDR;
            cfg_data_q <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            acc_q      <= acc_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rec_q      <= rec_d;
            gap_q      <= gap_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign config_addr     = cfg_addr_q;
    assign config_data     = cfg_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign records_written = rec_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench: one loader with a 1-cycle gap, one with no gap and a stalling source.
module tb_fabric_config_loader;

    localparam logic [31:0] IDLE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, busy, done, error;
    logic [31:0] config_addr, config_data;
    logic [15:0] records_written;

    logic        start0 = 1'b0, in_valid0 = 1'b0;
    logic [31:0] in_data0 = '0;
    logic        in_ready0, busy0, done0, error0;
    logic [31:0] config_addr0, config_data0;
    logic [15:0] records_written0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int bad_idle = 0;
    logic [63:0] wa_q[$];
    int          wc_q[$];
    logic [63:0] wb_q[$];

    fabric_config_loader #(.GAP_CYCLES(1), .IDLE_ADDR(IDLE)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .config_addr(config_addr), .config_data(config_data),
        .busy(busy), .done(done), .error(error), .records_written(records_written)
    );

    fabric_config_loader #(.GAP_CYCLES(0), .IDLE_ADDR(IDLE)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .config_addr(config_addr0), .config_data(config_data0),
        .busy(busy0), .done(done0), .error(error0), .records_written(records_written0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every bus write seen mid-cycle; an idle bus must carry zero data.
    always @(negedge clk) begin
        if (config_addr != IDLE) begin
            wa_q.push_back({config_addr, config_data});
            wc_q.push_back(cyc);
        end else if (config_data != 32'd0) begin
            bad_idle++;
        end
        if (config_addr0 != IDLE) wb_q.push_back({config_addr0, config_data0});
        else if (config_data0 != 32'd0) bad_idle++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_start0();
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    // Present one word and hold it until accepted.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Same, but with a bubble of in_valid=0 before each word.
    task automatic send0(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk); in_valid0 = 1'b0;
        @(negedge clk);
        in_valid0 = 1'b1;
        in_data0  = w;
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send0_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid0 = 1'b0;
    endtask

    task automatic wait_fin();
        int n;
        n = 0;
        while (!(done || error) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("fin_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_fin0();
        int n;
        n = 0;
        while (!(done0 || error0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("fin0_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_addr", config_addr, IDLE);
        check("rst_data", config_data, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_recs", records_written, 0);

        // Two-record frame, good checksum 0x00030005
        wa_q.delete(); wc_q.delete();
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_ready", in_ready, 1);
        send(32'd2); send(32'h0007_0003); send(32'h5); send(32'h0004_0003); send(32'h2);
        send(32'h0003_0005);
        wait_fin();
        check("t1_done", done, 1);
        check("t1_error", error, 0);
        check("t1_busy_end", busy, 0);
        check("t1_recs", records_written, 2);
        check("t1_nwr", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check("t1_w0", wa_q[0], {32'h0007_0003, 32'h5});
            check("t1_w1", wa_q[1], {32'h0004_0003, 32'h2});
            check("t1_spacing", wc_q[1] - wc_q[0], 4);
        end

        // Same frame, checksum bit0 flipped
        wa_q.delete(); wc_q.delete();
        pulse_start();
        check("t2_done_clr", done, 0);
        send(32'd2); send(32'h0007_0003); send(32'h5); send(32'h0004_0003); send(32'h2);
        send(32'h0003_0004);
        wait_fin();
        check("t2_error", error, 1);
        check("t2_done", done, 0);
        check("t2_recs", records_written, 2);
        check("t2_nwr", wa_q.size(), 2);

        // Bad section aborts immediately, nothing written
        wa_q.delete(); wc_q.delete();
        pulse_start();
        check("t3_error_clr", error, 0);
        send(32'd1); send(32'h0009_0001);
        check("t3_error", error, 1);
        check("t3_ready", in_ready, 0);
        check("t3_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("t3_nwr", wa_q.size(), 0);
        check("t3_recs", records_written, 0);

        // Empty frame
        wa_q.delete(); wc_q.delete();
        pulse_start();
        send(32'd0); send(32'd0);
        wait_fin();
        check("t4_done", done, 1);
        check("t4_error", error, 0);
        check("t4_recs", records_written, 0);
        check("t4_nwr", wa_q.size(), 0);

        // No-gap loader with a stalling source
        wb_q.delete();
        pulse_start0();
        send0(32'd2); send0(32'h0007_0003); send0(32'h5); send0(32'h0004_0003); send0(32'h2);
        send0(32'h0003_0005);
        wait_fin0();
        check("t5_done", done0, 1);
        check("t5_recs", records_written0, 2);
        check("t5_nwr", wb_q.size(), 2);
        if (wb_q.size() == 2) begin
            check("t5_w0", wb_q[0], {32'h0007_0003, 32'h5});
            check("t5_w1", wb_q[1], {32'h0004_0003, 32'h2});
        end

        // Reset in the WRITE cycle of record 2 of 3, then a clean reload
        pulse_start();
        send(32'd3); send(32'h0005_0001); send(32'hA); send(32'h0006_0002); send(32'hB);
        check("t6_in_write", config_addr, 32'h0006_0002);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("t6_rst_addr", config_addr, IDLE);
        check("t6_rst_data", config_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_recs", records_written, 0);
        wa_q.delete(); wc_q.delete();
        pulse_start();
        send(32'd3); send(32'h0005_0001); send(32'hA); send(32'h0006_0002); send(32'hB);
        send(32'h0007_0003); send(32'hC); send(32'h0004_000E);
        wait_fin();
        check("t6_done", done, 1);
        check("t6_recs", records_written, 3);
        check("t6_nwr", wa_q.size(), 3);
        if (wa_q.size() == 3) check("t6_w2", wa_q[2], {32'h0007_0003, 32'hC});

        check("idle_data_zero", bad_idle, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
